// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit multicycle stack processor datapath.
package cpu_pkg;

    localparam int unsigned WORD_W = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } stack_op_e;

    function automatic stack_op_e stack_op(input logic push, input logic pop);
        stack_op_e op;
        unique case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPL;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port, never cleared.
module stack_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/stack_8.sv
// LIFO operand stack with push, pop, replace-top and sticky overflow/underflow flags.
module stack_8
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         d_in,
    output logic [WIDTH-1:0]         tos,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0]    r_sp;
    logic             r_overflow;
    logic             r_underflow;

    logic [CW-1:0]    w_sp_d;
    logic [CW-1:0]    w_sp_m1;
    logic             w_empty;
    logic             w_full;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_rdata;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == CW'(DEPTH));
    assign w_sp_m1 = r_sp - CW'(1);

    always_comb begin
        w_sp_d    = r_sp;
        w_we      = 1'b0;
        w_waddr   = r_sp[AW-1:0];
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        unique case (stack_op(push, pop))
            OP_PUSH: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_we   = 1'b1;
                    w_sp_d = r_sp + CW'(1);
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_sp_d = w_sp_m1;
                end
            end
            OP_REPL: begin
                w_we = 1'b1;
                if (w_empty) begin
                    // Pop half is rejected, push half still lands in slot 0.
                    w_unf_set = 1'b1;
                    w_sp_d    = CW'(1);
                end else begin
                    w_waddr = w_sp_m1[AW-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_sp_d;
            r_overflow  <= r_overflow | w_ovf_set;
            r_underflow <= r_underflow | w_unf_set;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_we && !rst),
        .waddr (w_waddr),
        .wdata (d_in),
        .raddr (w_sp_m1[AW-1:0]),
        .rdata (w_rdata)
    );

    assign tos       = w_empty ? '0 : w_rdata;
    assign count     = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_stack_8.sv
// Self-checking bench for stack_8: directed scenarios plus random traffic against a queue model.
module tb_stack_8;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] d_in = '0;
    logic [7:0] tos;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    stack_8 #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .d_in      (d_in),
        .tos       (tos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic p, input logic po, input logic [7:0] d);
        rst  = r;
        push = p;
        pop  = po;
        d_in = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (p && !po) begin
            if (q.size() == DEPTH) m_ovf = 1'b1;
            else q.push_back(d);
        end else if (po && !p) begin
            if (q.size() == 0) m_unf = 1'b1;
            else void'(q.pop_back());
        end else if (p && po) begin
            if (q.size() == 0) begin
                m_unf = 1'b1;
                q.push_back(d);
            end else begin
                q[q.size()-1] = d;
            end
        end
        #1;
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            n_fail++; $display("FAIL reset_empty_full: got %b%b want 10", empty, full);
        end
        n_checks++;
        if (tos !== 8'h00) begin n_fail++; $display("FAIL reset_tos: got %h want 00", tos); end
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b%b want 00", overflow, underflow);
        end
    endtask

    task automatic test_push_pop();
        cyc(1'b0, 1'b1, 1'b0, 8'h11);
        n_checks++;
        if (tos !== 8'h11) begin n_fail++; $display("FAIL push1_latency: got %h want 11", tos); end
        cyc(1'b0, 1'b1, 1'b0, 8'h22);
        cyc(1'b0, 1'b1, 1'b0, 8'h33);
        n_checks++;
        if (tos !== 8'h33 || count !== 5'd3) begin
            n_fail++; $display("FAIL push3: got tos=%h count=%0d want 33/3", tos, count);
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (tos !== 8'h22 || count !== 5'd2) begin
            n_fail++; $display("FAIL pop1: got tos=%h count=%0d want 22/2", tos, count);
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (empty !== 1'b1 || tos !== 8'h00 || count !== 5'd0) begin
            n_fail++; $display("FAIL pop_all: got empty=%b tos=%h count=%0d want 1/00/0",
                               empty, tos, count);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= DEPTH; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
        n_checks++;
        if (full !== 1'b1 || tos !== 8'h10 || count !== 5'd16) begin
            n_fail++; $display("FAIL fill: got full=%b tos=%h count=%0d want 1/10/16",
                               full, tos, count);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'hAA);
        n_checks++;
        if (tos !== 8'h10 || count !== 5'd16 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow: got tos=%h count=%0d ovf=%b want 10/16/1",
                               tos, count, overflow);
        end
        cyc(1'b0, 1'b1, 1'b1, 8'hBB);
        n_checks++;
        if (tos !== 8'hBB || count !== 5'd16 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL repl_full: got tos=%h count=%0d ovf=%b want BB/16/1",
                               tos, count, overflow);
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (tos !== 8'h0F || count !== 5'd15 || full !== 1'b0) begin
            n_fail++; $display("FAIL pop_from_full: got tos=%h count=%0d full=%b want 0F/15/0",
                               tos, count, full);
        end
    endtask

    task automatic test_underflow();
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (underflow !== 1'b1 || count !== 5'd0) begin
            n_fail++; $display("FAIL underflow: got unf=%b count=%0d want 1/0", underflow, count);
        end
        cyc(1'b0, 1'b1, 1'b1, 8'h5A);
        n_checks++;
        if (count !== 5'd1 || tos !== 8'h5A || underflow !== 1'b1) begin
            n_fail++; $display("FAIL repl_empty: got count=%0d tos=%h unf=%b want 1/5A/1",
                               count, tos, underflow);
        end
    endtask

    task automatic test_reset_dominates();
        cyc(1'b0, 1'b1, 1'b0, 8'h77);
        cyc(1'b1, 1'b1, 1'b0, 8'h99);
        n_checks++;
        if (count !== 5'd0 || tos !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL rst_push: got count=%0d tos=%h flags=%b%b want 0/00/00",
                               count, tos, overflow, underflow);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h42);
        n_checks++;
        if (tos !== 8'h42 || count !== 5'd1) begin
            n_fail++; $display("FAIL push_after_rst: got tos=%h count=%0d want 42/1", tos, count);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_tos;
        int         thr;
        for (int i = 0; i < 1000; i++) begin
            // Bias shifts between push-heavy and pop-heavy phases to hit both ends.
            thr = ((i / 125) % 2 == 0) ? 75 : 25;
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 99) < thr),
                ($urandom_range(0, 99) >= thr),
                8'($urandom));
            exp_tos = (q.size() == 0) ? 8'h00 : q[q.size()-1];
            n_checks++;
            if (tos !== exp_tos) begin
                n_fail++; $display("FAIL rnd_tos[%0d]: got %h want %h", i, tos, exp_tos);
            end
            n_checks++;
            if (count !== 5'(q.size())) begin
                n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, q.size());
            end
            n_checks++;
            if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
                n_fail++; $display("FAIL rnd_empty_full[%0d]: got %b%b want %b%b", i, empty,
                                   full, (q.size() == 0), (q.size() == DEPTH));
            end
            n_checks++;
            if (overflow !== m_ovf || underflow !== m_unf) begin
                n_fail++; $display("FAIL rnd_flags[%0d]: got %b%b want %b%b", i, overflow,
                                   underflow, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_push_pop();
        test_fill_overflow();
        test_underflow();
        test_reset_dominates();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
